// File: rtl/bin_buffer_ctrl_if.sv
// ---------------------------------------------------------------------------
// bin_buffer_ctrl_if
// Bundles the signals between the binning stage, the frame-buffer BRAM and the
// downstream frame consumer.
//   slave  : controller side (takes pixels and consumer handshakes, drives
//            the BRAM write port, grant, bank selects and drop counter)
//   master : environment side (the mirror image)
// ---------------------------------------------------------------------------
interface bin_buffer_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic              bin_valid_in;
    logic [8:0]        bin_hcount_in;
    logic [7:0]        bin_vcount_in;
    logic              bin_data_in;
    logic              wr_en_out;
    logic [ADDR_W-1:0] wr_addr_out;
    logic              wr_data_out;
    logic              frame_req_in;
    logic              frame_grant_out;
    logic              rd_bank_out;
    logic              frame_release_in;
    logic              wr_bank_out;
    logic [7:0]        frames_dropped_out;

    modport slave (
        input  bin_valid_in, bin_hcount_in, bin_vcount_in, bin_data_in,
        input  frame_req_in, frame_release_in,
        output wr_en_out, wr_addr_out, wr_data_out,
        output frame_grant_out, rd_bank_out, wr_bank_out, frames_dropped_out
    );

    modport master (
        output bin_valid_in, bin_hcount_in, bin_vcount_in, bin_data_in,
        output frame_req_in, frame_release_in,
        input  wr_en_out, wr_addr_out, wr_data_out,
        input  frame_grant_out, rd_bank_out, wr_bank_out, frames_dropped_out
    );
endinterface

// File: rtl/bin_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// bin_buffer_ctrl
// Ping-pong frame-buffer controller behind the 4x4 binning stage. Binned
// pixels become BRAM writes into one of two banks; a completed bank is handed
// to a consumer through request/grant/release. The consumer never sees a
// partially written bank.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-high reset
//   bus (slave)    : pixel stream in, BRAM write port out ({bank, v*W+h}),
//                    frame_req/grant/release handshake, rd_bank/wr_bank,
//                    saturating dropped-frame counter
// ---------------------------------------------------------------------------
module bin_buffer_ctrl #(
    parameter int BIN_W  = 320,
    parameter int BIN_H  = 180,
    parameter int ADDR_W = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    bin_buffer_ctrl_if.slave  bus
);
    typedef enum logic {WAIT_SOF, FILL} state_t;

    localparam logic [31:0] W32 = 32'(BIN_W);
    localparam logic [31:0] H32 = 32'(BIN_H);

    state_t            state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_data_q, wr_data_d;
    logic              grant_q, grant_d;
    logic              rd_bank_q, rd_bank_d;
    logic              wr_bank_q, wr_bank_d;
    logic [7:0]        dropped_q, dropped_d;
    logic [1:0]        full_q, full_d;
    logic              lock_q, lock_d;
    logic              latest_q, latest_d;

    logic [31:0] pix_h, pix_v, lin_addr;
    logic        in_range, pix_ok, is_sof, is_eof;
    logic        grant, release_ok, tgt_bank;

    always_comb begin
        // Full-width arithmetic so out-of-range coordinates cannot alias
        // into a legal address before the range check.
        pix_h    = 32'(bus.bin_hcount_in);
        pix_v    = 32'(bus.bin_vcount_in);
        lin_addr = pix_v * W32 + pix_h;
        in_range = (pix_h < W32) && (pix_v < H32);
        pix_ok   = bus.bin_valid_in && in_range;
        is_sof   = pix_ok && (pix_h == 32'd0) && (pix_v == 32'd0);
        is_eof   = pix_ok && (pix_h == W32 - 32'd1) && (pix_v == H32 - 32'd1);

        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        grant_d   = 1'b0;
        rd_bank_d = rd_bank_q;
        wr_bank_d = wr_bank_q;
        dropped_d = dropped_q;
        full_d    = full_q;
        lock_d    = lock_q;
        latest_d  = latest_q;

        // Reader arbitration works from registered state only; a release
        // cycle never grants, even with a request pending.
        release_ok = bus.frame_release_in && lock_q;
        grant = !lock_q && !bus.frame_release_in && bus.frame_req_in &&
                full_q[latest_q] &&
                ((latest_q != wr_bank_q) || (state_q == WAIT_SOF));

        if (release_ok) begin
            lock_d             = 1'b0;
            full_d[rd_bank_q]  = 1'b0;
        end
        if (grant) begin
            grant_d   = 1'b1;
            rd_bank_d = latest_q;
            lock_d    = 1'b1;
        end

        // Idle writer whose current bank has just been (or is being) handed
        // to the consumer moves to the other bank, so it can never write
        // into the consumer's bank.
        tgt_bank = (lock_d && (rd_bank_d == wr_bank_q)) ? ~wr_bank_q : wr_bank_q;

        case (state_q)
            WAIT_SOF: begin
                wr_bank_d = tgt_bank;
                if (is_sof) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {tgt_bank, lin_addr[ADDR_W-2:0]};
                    wr_data_d = bus.bin_data_in;
                    // A full bank here was never granted (granted banks are
                    // either locked or already released), so this is a drop.
                    if (full_q[tgt_bank] && (dropped_q != 8'hFF))
                        dropped_d = dropped_q + 8'd1;
                    full_d[tgt_bank] = 1'b0;
                    state_d   = FILL;
                end
            end
            FILL: begin
                // (0,0) here is a resync: written like any other pixel, the
                // frame simply restarts in the same bank.
                if (pix_ok) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {wr_bank_q, lin_addr[ADDR_W-2:0]};
                    wr_data_d = bus.bin_data_in;
                end
                if (is_eof) begin
                    full_d[wr_bank_q] = 1'b1;
                    latest_d          = wr_bank_q;
                    state_d           = WAIT_SOF;
                    // Stay on our bank if the consumer owns the other one.
                    wr_bank_d = (lock_d && (rd_bank_d == ~wr_bank_q)) ?
                                wr_bank_q : ~wr_bank_q;
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= WAIT_SOF;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 1'b0;
            grant_q   <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_bank_q <= 1'b0;
            dropped_q <= 8'd0;
            full_q    <= 2'b00;
            lock_q    <= 1'b0;
            latest_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            grant_q   <= grant_d;
            rd_bank_q <= rd_bank_d;
            wr_bank_q <= wr_bank_d;
            dropped_q <= dropped_d;
            full_q    <= full_d;
            lock_q    <= lock_d;
            latest_q  <= latest_d;
        end
    end

    assign bus.wr_en_out          = wr_en_q;
    assign bus.wr_addr_out        = wr_addr_q;
    assign bus.wr_data_out        = wr_data_q;
    assign bus.frame_grant_out    = grant_q;
    assign bus.rd_bank_out        = rd_bank_q;
    assign bus.wr_bank_out        = wr_bank_q;
    assign bus.frames_dropped_out = dropped_q;
endmodule

// File: tb/tb_bin_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bin_buffer_ctrl
// Directed bench for bin_buffer_ctrl. Full width (320) with a short frame
// height (6 rows) so several whole frames fit in a short run; the address
// formula, bank behaviour and drop accounting are height-independent.
// ---------------------------------------------------------------------------
module tb_bin_buffer_ctrl;
    localparam int W  = 320;
    localparam int H  = 6;
    localparam int AW = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bin_buffer_ctrl_if #(.ADDR_W(AW)) bus();

    bin_buffer_ctrl #(.BIN_W(W), .BIN_H(H), .ADDR_W(AW)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int nwr, nbad, nb0, nb1, ngr;
    logic [AW-1:0] a52;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one pixel for one cycle; its write is visible #1 after the edge.
    task automatic px(input int h, input int v, input logic d);
        bus.bin_valid_in  = 1'b1;
        bus.bin_hcount_in = 9'(h);
        bus.bin_vcount_in = 8'(v);
        bus.bin_data_in   = d;
        @(posedge clk); #1;
        bus.bin_valid_in  = 1'b0;
        if (bus.wr_en_out) begin
            nwr++;
            if (bus.wr_addr_out[AW-1]) nb1++; else nb0++;
        end
    endtask

    // Raster from (h0,v0) up to row vend-1, checking each write against
    // {bank, v*W+h} and the driven data bit.
    task automatic raster(input int h0, input int v0, input int vend, input logic bank);
        logic [AW-1:0] ea;
        logic d;
        nwr = 0; nbad = 0; nb0 = 0; nb1 = 0;
        for (int v = v0; v < vend; v++) begin
            for (int h = (v == v0) ? h0 : 0; h < W; h++) begin
                d  = 1'((h ^ v) & 1);
                ea = {bank, 16'(v * W + h)};
                px(h, v, d);
                if (h == 5 && v == 2) a52 = bus.wr_addr_out;
                if (bus.wr_en_out && (bus.wr_addr_out !== ea || bus.wr_data_out !== d))
                    nbad++;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    initial begin
        bus.bin_valid_in     = 1'b0;
        bus.bin_hcount_in    = '0;
        bus.bin_vcount_in    = '0;
        bus.bin_data_in      = 1'b0;
        bus.frame_req_in     = 1'b0;
        bus.frame_release_in = 1'b0;
        a52 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en",   32'(bus.wr_en_out), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr_out), 32'd0);
        chk("rst_grant",   32'(bus.frame_grant_out), 32'd0);
        chk("rst_wr_bank", 32'(bus.wr_bank_out), 32'd0);
        chk("rst_dropped", 32'(bus.frames_dropped_out), 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Frame 0 into bank 0
        raster(0, 0, H, 1'b0);
        chk("f0_writes",   32'(nwr), 32'(W * H));
        chk("f0_badaddr",  32'(nbad), 32'd0);
        chk("f0_bank1",    32'(nb1), 32'd0);
        chk("f0_addr_5_2", 32'(a52), 32'd645);
        chk("f0_wr_bank",  32'(bus.wr_bank_out), 32'd1);

        // Grant bank 0
        bus.frame_req_in = 1'b1;
        cyc();
        chk("g0_grant",   32'(bus.frame_grant_out), 32'd1);
        chk("g0_rd_bank", 32'(bus.rd_bank_out), 32'd0);
        bus.frame_req_in = 1'b0;
        cyc();
        chk("g0_pulse",   32'(bus.frame_grant_out), 32'd0);

        // Frames 1..3 while bank 0 is held: all go to bank 1, two drops
        raster(0, 0, H, 1'b1);
        chk("f1_writes",  32'(nwr), 32'(W * H));
        chk("f1_badaddr", 32'(nbad), 32'd0);
        chk("f1_bank0",   32'(nb0), 32'd0);
        chk("f1_dropped", 32'(bus.frames_dropped_out), 32'd0);
        chk("f1_wr_bank", 32'(bus.wr_bank_out), 32'd1);
        raster(0, 0, H, 1'b1);
        chk("f2_bank0",   32'(nb0), 32'd0);
        chk("f2_dropped", 32'(bus.frames_dropped_out), 32'd1);
        raster(0, 0, H, 1'b1);
        chk("f3_badaddr", 32'(nbad), 32'd0);
        chk("f3_bank0",   32'(nb0), 32'd0);
        chk("f3_dropped", 32'(bus.frames_dropped_out), 32'd2);

        // Release with request in the same cycle: no grant until next cycle
        bus.frame_release_in = 1'b1;
        bus.frame_req_in     = 1'b1;
        cyc();
        chk("rel_no_grant", 32'(bus.frame_grant_out), 32'd0);
        bus.frame_release_in = 1'b0;
        cyc();
        chk("g1_grant",   32'(bus.frame_grant_out), 32'd1);
        chk("g1_rd_bank", 32'(bus.rd_bank_out), 32'd1);
        chk("g1_wr_bank", 32'(bus.wr_bank_out), 32'd0);
        bus.frame_req_in = 1'b0;

        // Release bank 1; request with nothing full waits without a grant
        bus.frame_release_in = 1'b1;
        cyc();
        bus.frame_release_in = 1'b0;
        bus.frame_req_in     = 1'b1;
        ngr = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (bus.frame_grant_out) ngr++;
        end
        chk("empty_req_grants", 32'(ngr), 32'd0);
        bus.frame_req_in = 1'b0;

        // Out-of-range pixels: no write, still waiting for start of frame
        nwr = 0; nb0 = 0; nb1 = 0;
        px(W, 0, 1'b1);
        chk("oor_h320", 32'(bus.wr_en_out), 32'd0);
        px(0, 180, 1'b1);
        chk("oor_v180", 32'(bus.wr_en_out), 32'd0);
        px(0, H, 1'b1);
        chk("oor_vH", 32'(bus.wr_en_out), 32'd0);
        px(5, 1, 1'b1);
        chk("oor_still_wait", 32'(bus.wr_en_out), 32'd0);

        // Mid-frame start: nothing until (0,0), then a normal frame in bank 0
        raster(17, 2, H, 1'b0);
        chk("mid_writes", 32'(nwr), 32'd0);
        raster(0, 0, H, 1'b0);
        chk("mid_f_writes",  32'(nwr), 32'(W * H));
        chk("mid_f_badaddr", 32'(nbad), 32'd0);
        chk("mid_f_bank1",   32'(nb1), 32'd0);
        chk("mid_f_dropped", 32'(bus.frames_dropped_out), 32'd2);
        chk("mid_f_wr_bank", 32'(bus.wr_bank_out), 32'd1);

        // Asynchronous reset part way through a frame into bank 1
        raster(0, 0, 3, 1'b1);
        bus.bin_valid_in  = 1'b1;
        bus.bin_hcount_in = 9'd0;
        bus.bin_vcount_in = 8'd3;
        #2 rst = 1'b1;
        #1;
        chk("arst_wr_en",   32'(bus.wr_en_out), 32'd0);
        chk("arst_wr_addr", 32'(bus.wr_addr_out), 32'd0);
        chk("arst_rd_bank", 32'(bus.rd_bank_out), 32'd0);
        chk("arst_wr_bank", 32'(bus.wr_bank_out), 32'd0);
        chk("arst_dropped", 32'(bus.frames_dropped_out), 32'd0);
        bus.bin_valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        raster(0, 0, H, 1'b0);
        chk("post_rst_writes",  32'(nwr), 32'(W * H));
        chk("post_rst_badaddr", 32'(nbad), 32'd0);
        chk("post_rst_bank1",   32'(nb1), 32'd0);
        chk("post_rst_dropped", 32'(bus.frames_dropped_out), 32'd0);
        chk("post_rst_wr_bank", 32'(bus.wr_bank_out), 32'd1);
        bus.frame_req_in = 1'b1;
        cyc();
        chk("post_rst_grant",   32'(bus.frame_grant_out), 32'd1);
        chk("post_rst_rd_bank", 32'(bus.rd_bank_out), 32'd0);
        bus.frame_req_in = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
